// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    // Lowest-index active-low row wins when several rows are pulled at once.
    // Returns 0 when no row is low; callers must qualify with an any-low check.
    function automatic logic [1:0] row_hit(input logic [NUM_ROWS-1:0] rows_n);
        row_hit = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) begin
                row_hit = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing one scan tick every SCAN_DIV clocks.
// Latency: tick is high during the cycle the count sits at SCAN_DIV-1.
// Backpressure: none; runs regardless of scanner state.
module scan_tick_gen #(
    parameter int SCAN_DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wrap to zero after the terminal count, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning 4x4 keypad reader with press/release debounce and one-shot key strobe.
// Latency: DEBOUNCE_SCANS ticks + 1 clk from an aligned stable press, plus up to 3 ticks of column search.
// Backpressure: none; key_valid is a single-cycle strobe the consumer must capture.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] rows_s_q;

    state_t     state_q,    state_d;
    logic [1:0] col_q,      col_d;
    logic [1:0] cand_row_q, cand_row_d;
    logic [1:0] cand_col_q, cand_col_d;
    logic [3:0] deb_cnt_q,  deb_cnt_d;
    logic [3:0] rel_cnt_q,  rel_cnt_d;
    key_code_t  code_q,     code_d;
    logic       valid_q,    valid_d;
    logic       held_q,     held_d;

    logic       all_high;
    logic [1:0] hit;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous row inputs; idles at "no key".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            rows_s_q   <= '1;
        end else begin
            row_meta_q <= row_n;
            rows_s_q   <= row_meta_q;
        end
    end

    assign all_high = &rows_s_q;
    assign hit      = row_hit(rows_s_q);

    // Scan/debounce/hold next-state logic; every decision is gated by the scan tick.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        deb_cnt_d  = deb_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (all_high) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        cand_row_d = hit;
                        cand_col_d = col_q;
                        if (DEB_N == 4'd1) begin
                            code_d    = {hit, col_q};
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            deb_cnt_d = '0;
                            state_d   = HOLD;
                        end else begin
                            deb_cnt_d = 4'd1;
                            state_d   = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!all_high && hit == cand_row_q) begin
                        if (deb_cnt_q + 4'd1 == DEB_N) begin
                            code_d    = {cand_row_q, cand_col_q};
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            deb_cnt_d = '0;
                            state_d   = HOLD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 4'd1;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        col_d     = col_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HOLD: begin
                    if (all_high) begin
                        if (rel_cnt_q + 4'd1 == DEB_N) begin
                            rel_cnt_d = '0;
                            held_d    = 1'b0;
                            col_d     = col_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 4'd1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Scanner state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            col_q      <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            deb_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            deb_cnt_q  <= deb_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural key-matrix model.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_matrix_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Up to two pressed keys; a key pulls its row low only while its column is driven.
    logic       k0_en, k1_en;
    logic [1:0] k0_r, k0_c, k1_r, k1_c;

    int compared   = 0;
    int mismatched = 0;
    int last_code  = 0;

    typedef struct {
        logic       two;
        logic [1:0] r0;
        logic [1:0] c0;
        logic [1:0] r1;
        logic [1:0] c1;
        int         hold_ticks;
        int         exp_code;
    } vec_t;

    vec_t tbl[5];

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        if (k0_en && !col_n[k0_c]) row_n[k0_r] = 1'b0;
        if (k1_en && !col_n[k1_c]) row_n[k1_r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Press the given key(s) for hold_ticks scan periods, release, and verify one strobe.
    task automatic run_press(input logic two, input logic [1:0] r0, input logic [1:0] c0,
                             input logic [1:0] r1, input logic [1:0] c1,
                             input int hold_ticks, input int exp_code);
        int  pulses;
        bit  prev;
        bit  consec;
        int  waited;
        pulses = 0;
        prev   = 1'b0;
        consec = 1'b0;
        k0_r = r0; k0_c = c0; k1_r = r1; k1_c = c1;
        k0_en = 1'b1;
        k1_en = two;
        for (int i = 0; i < hold_ticks * 4; i++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                if (prev) consec = 1'b1;
            end
            prev = key_valid;
        end
        check("press_code", int'(key_code), exp_code);
        check("press_held", int'(key_held), 1);
        k0_en = 1'b0;
        k1_en = 1'b0;
        waited = 0;
        while (key_held && waited < 40) begin
            @(negedge clk);
            waited++;
            if (key_valid) begin
                pulses++;
                if (prev) consec = 1'b1;
            end
            prev = key_valid;
        end
        check("release_held", int'(key_held), 0);
        check("pulse_count", pulses, 1);
        check("no_back_to_back_valid", int'(consec), 0);
        check("code_kept_after_release", int'(key_code), exp_code);
        last_code = exp_code;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int waited;
        logic [3:0] exp_col;

        tbl[0] = '{two: 1'b0, r0: 2'd2, c0: 2'd1, r1: 2'd0, c1: 2'd0, hold_ticks: 40, exp_code: 9};
        tbl[1] = '{two: 1'b1, r0: 2'd1, c0: 2'd3, r1: 2'd3, c1: 2'd3, hold_ticks: 40, exp_code: 7};
        tbl[2] = '{two: 1'b0, r0: 2'd3, c0: 2'd3, r1: 2'd0, c1: 2'd0, hold_ticks: 40, exp_code: 15};
        tbl[3] = '{two: 1'b0, r0: 2'd1, c0: 2'd2, r1: 2'd0, c1: 2'd0, hold_ticks: 40, exp_code: 6};
        tbl[4] = '{two: 1'b0, r0: 2'd0, c0: 2'd0, r1: 2'd0, c1: 2'd0, hold_ticks: 50, exp_code: 0};

        k0_en = 1'b0; k1_en = 1'b0;
        k0_r = 2'd0; k0_c = 2'd0; k1_r = 2'd0; k1_c = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_col_n", int'(col_n), 4'b1110);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);

        // Column rotation: one step every 4 clocks once reset is released.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("col_rotation", int'(col_n), int'(exp_col));
        end

        // Table of clean presses.
        for (int v = 0; v < 5; v++) begin
            run_press(tbl[v].two, tbl[v].r0, tbl[v].c0, tbl[v].r1, tbl[v].c1,
                      tbl[v].hold_ticks, tbl[v].exp_code);
        end

        // Bounce: key 9 seen on two ticks of column 1, gone on the third.
        waited = 0;
        while (col_n == 4'b1101 && waited < 40) begin @(negedge clk); waited++; end
        while (col_n != 4'b1101 && waited < 40) begin @(negedge clk); waited++; end
        check("bounce_align_col1", int'(col_n), 4'b1101);
        pulses = 0;
        k0_r = 2'd2; k0_c = 2'd1; k0_en = 1'b1;
        repeat (8) begin @(negedge clk); if (key_valid) pulses++; end
        k0_en = 1'b0;
        repeat (4) begin @(negedge clk); if (key_valid) pulses++; end
        check("bounce_col_advanced", int'(col_n), 4'b1011);
        repeat (20) begin @(negedge clk); if (key_valid) pulses++; end
        check("bounce_no_strobe", pulses, 0);
        check("bounce_not_held", int'(key_held), 0);
        check("bounce_code_unchanged", int'(key_code), last_code);
        run_press(1'b0, 2'd2, 2'd1, 2'd0, 2'd0, 40, 9);

        // Reset while holding key 5; the key is re-detected afterwards.
        k0_r = 2'd1; k0_c = 2'd1; k0_en = 1'b1;
        waited = 0;
        while (!key_held && waited < 200) begin @(negedge clk); waited++; end
        check("midhold_held_before_rst", int'(key_held), 1);
        check("midhold_code_before_rst", int'(key_code), 5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midhold_rst_col_n", int'(col_n), 4'b1110);
        check("midhold_rst_code", int'(key_code), 0);
        check("midhold_rst_valid", int'(key_valid), 0);
        check("midhold_rst_held", int'(key_held), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_press(1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 40, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
